// File: rtl/mag_drive_pkg.sv
// Shared steering-code definitions for the magnetic-sensor and motor-drive blocks.
package mag_drive_pkg;
  localparam logic [3:0] DIR_FWD   = 4'b0000;
  localparam logic [3:0] DIR_LEFT  = 4'b0101;
  localparam logic [3:0] DIR_RIGHT = 4'b1001;
  localparam logic [3:0] DIR_STOP  = 4'b1111;

  typedef enum logic {STOP = 1'b0, RUN = 1'b1} drive_state_e;

  // Anything other than the three motion codes is treated as stop.
  function automatic logic dir_is_go(input logic [3:0] d);
    return (d == DIR_FWD) || (d == DIR_LEFT) || (d == DIR_RIGHT);
  endfunction
endpackage

// File: rtl/motor_pwm_chan.sv
// One motor channel: duty register ramped toward a target at period boundaries, plus PWM compare.
module motor_pwm_chan #(
  parameter int CW        = 10,
  parameter int DW        = 10,
  parameter int RAMP_STEP = 50
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] target,
  input  logic          step_en,
  input  logic          force_zero,
  input  logic [CW-1:0] cnt,
  output logic [DW-1:0] duty_next,
  output logic          pwm
);
  localparam logic [DW-1:0] STEP = DW'(RAMP_STEP);

  logic [DW-1:0] duty;

  // Compare before add/subtract so the step never overshoots the target.
  always_comb begin
    duty_next = duty;
    if (force_zero) begin
      duty_next = '0;
    end else if (step_en) begin
      if (target > duty)
        duty_next = (target - duty > STEP) ? duty + STEP : target;
      else if (target < duty)
        duty_next = (duty - target > STEP) ? duty - STEP : target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty <= '0;
      pwm  <= 1'b0;
    end else begin
      duty <= duty_next;
      pwm  <= !force_zero && (DW'(cnt) < duty);
    end
  end
endmodule

// File: rtl/motor_drive.sv
// Steering-code to dual H-bridge PWM driver with per-period duty ramping and immediate brake.
module motor_drive
  import mag_drive_pkg::*;
#(
  parameter int PWM_PERIOD = 1000,
  parameter int SLOW_DUTY  = 500,
  parameter int RAMP_STEP  = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] DIR,
  output logic       PWM_L,
  output logic       PWM_R,
  output logic       BRAKE,
  output logic       MOVING
);
  localparam int CW = $clog2(PWM_PERIOD);
  localparam int DW = $clog2(PWM_PERIOD + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PWM_PERIOD - 1);
  localparam logic [DW-1:0] FULL     = DW'(PWM_PERIOD);
  localparam logic [DW-1:0] SLOW     = DW'(SLOW_DUTY);

  logic [3:0]    dir_q;
  logic [CW-1:0] cnt;
  drive_state_e  state, state_nxt;
  logic          go, boundary;
  logic [DW-1:0] tgt_l, tgt_r, duty_l_nxt, duty_r_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q <= DIR_STOP;
      cnt   <= '0;
    end else begin
      dir_q <= DIR;
      cnt   <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end
  end

  always_comb begin
    go       = dir_is_go(dir_q);
    boundary = (cnt == CNT_LAST);
    tgt_l    = '0;
    tgt_r    = '0;
    case (dir_q)
      DIR_FWD:   begin tgt_l = FULL; tgt_r = FULL; end
      DIR_LEFT:  begin tgt_l = SLOW; tgt_r = FULL; end
      DIR_RIGHT: begin tgt_l = FULL; tgt_r = SLOW; end
      default:   ;
    endcase
  end

  // Stop wins over everything; leaving STOP waits for a boundary so the
  // first ramp step lands on a whole period.
  always_comb begin
    state_nxt = state;
    if (!go)
      state_nxt = STOP;
    else if (boundary)
      state_nxt = RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= STOP;
      BRAKE  <= 1'b1;
      MOVING <= 1'b0;
    end else begin
      state  <= state_nxt;
      BRAKE  <= (state_nxt == STOP);
      MOVING <= (state_nxt == RUN) && ((duty_l_nxt != '0) || (duty_r_nxt != '0));
    end
  end

  motor_pwm_chan #(.CW(CW), .DW(DW), .RAMP_STEP(RAMP_STEP)) u_chan_l (
    .clk        (clk),
    .rst_n      (rst_n),
    .target     (tgt_l),
    .step_en    (boundary && go),
    .force_zero (!go),
    .cnt        (cnt),
    .duty_next  (duty_l_nxt),
    .pwm        (PWM_L)
  );

  motor_pwm_chan #(.CW(CW), .DW(DW), .RAMP_STEP(RAMP_STEP)) u_chan_r (
    .clk        (clk),
    .rst_n      (rst_n),
    .target     (tgt_r),
    .step_en    (boundary && go),
    .force_zero (!go),
    .cnt        (cnt),
    .duty_next  (duty_r_nxt),
    .pwm        (PWM_R)
  );
endmodule

// File: tb/tb_motor_drive.sv
// Directed and randomized checks of motor_drive against a cycle-level behavioural model.
module tb_motor_drive;
  localparam int P  = 20;
  localparam int SD = 10;
  localparam int RS = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] DIR = 4'h0;
  logic       PWM_L, PWM_R, BRAKE, MOVING;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  motor_drive #(.PWM_PERIOD(P), .SLOW_DUTY(SD), .RAMP_STEP(RS)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .DIR    (DIR),
    .PWM_L  (PWM_L),
    .PWM_R  (PWM_R),
    .BRAKE  (BRAKE),
    .MOVING (MOVING)
  );

  // Reference model: integer duties, period position and a run flag.
  int         m_cnt = 0, m_dl = 0, m_dr = 0;
  logic [3:0] m_dirq = 4'hF;
  bit         m_run = 0, m_pl = 0, m_pr = 0, m_brk = 1, m_mov = 0;

  function automatic bit legal(input logic [3:0] d);
    return d == 4'h0 || d == 4'h5 || d == 4'h9;
  endfunction

  function automatic int tgt(input logic [3:0] d, input bit left);
    case (d)
      4'h0:    return P;
      4'h5:    return left ? SD : P;
      4'h9:    return left ? P : SD;
      default: return 0;
    endcase
  endfunction

  function automatic int approach(input int d, input int t);
    if (t > d) return d + ((t - d < RS) ? t - d : RS);
    return d - ((d - t < RS) ? d - t : RS);
  endfunction

  function automatic int nxt_duty(input int d, input logic [3:0] q, input int c, input bit left);
    if (!legal(q)) return 0;
    if (c == P - 1) return approach(d, tgt(q, left));
    return d;
  endfunction

  function automatic bit nxt_run(input bit r, input logic [3:0] q, input int c);
    return legal(q) && (r || c == P - 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0; m_dirq <= 4'hF; m_run <= 0; m_dl <= 0; m_dr <= 0;
      m_pl <= 0; m_pr <= 0; m_brk <= 1; m_mov <= 0;
    end else begin
      m_pl  <= legal(m_dirq) && (m_cnt < m_dl);
      m_pr  <= legal(m_dirq) && (m_cnt < m_dr);
      m_dl  <= nxt_duty(m_dl, m_dirq, m_cnt, 1'b1);
      m_dr  <= nxt_duty(m_dr, m_dirq, m_cnt, 1'b0);
      m_run <= nxt_run(m_run, m_dirq, m_cnt);
      m_brk <= !nxt_run(m_run, m_dirq, m_cnt);
      m_mov <= nxt_run(m_run, m_dirq, m_cnt) &&
               (nxt_duty(m_dl, m_dirq, m_cnt, 1'b1) != 0 || nxt_duty(m_dr, m_dirq, m_cnt, 1'b0) != 0);
      m_cnt <= (m_cnt + 1) % P;
      m_dirq <= DIR;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("outs{L,R,BRK,MOV}", int'({PWM_L, PWM_R, BRAKE, MOVING}),
        int'({m_pl, m_pr, m_brk, m_mov}));
  endtask

  task automatic wait_cnt(input int v);
    int n = 0;
    do begin
      tick();
      n++;
    end while (m_cnt != v && n < 4 * P);
    if (m_cnt != v) chk("wait_cnt_timeout", m_cnt, v);
  endtask

  // Count high cycles over one whole period; called right after a boundary edge.
  task automatic measure(input string tag, input int exp_l, input int exp_r);
    int hl = 0, hr = 0;
    repeat (P) begin
      tick();
      hl += int'(PWM_L);
      hr += int'(PWM_R);
    end
    chk({tag, "_L_highs"}, hl, exp_l);
    chk({tag, "_R_highs"}, hr, exp_r);
  endtask

  initial begin
    logic [3:0] codes [5];
    codes[0] = 4'h0; codes[1] = 4'h5; codes[2] = 4'h9; codes[3] = 4'hF; codes[4] = 4'h6;

    DIR = 4'h0;
    #2 rst_n = 1'b0;
    #1 chk("reset_outs", int'({PWM_L, PWM_R, BRAKE, MOVING}), 4'b0010);
    tick(); tick();
    rst_n = 1'b1;

    // Ramp from stop to full forward.
    wait_cnt(0);
    measure("ramp5", 5, 5);
    measure("ramp10", 10, 10);
    measure("ramp15", 15, 15);
    measure("ramp20", 20, 20);

    // Veer left, then right.
    DIR = 4'h5;
    measure("veerL_hold", 20, 20);
    measure("veerL_1", 15, 20);
    measure("veerL_2", 10, 20);
    chk("veer_moving", int'(MOVING), 1);
    DIR = 4'h9;
    measure("veerR_hold", 10, 20);
    measure("veerR_1", 15, 15);
    measure("veerR_2", 20, 10);
    DIR = 4'h0;
    measure("fwd_hold", 20, 10);
    measure("fwd_1", 20, 15);
    measure("fwd_2", 20, 20);

    // Stop mid-period: two-clock latency, then silence.
    wait_cnt(7);
    DIR = 4'hF;
    tick();
    chk("stop_edge_k_L", int'(PWM_L), 1);
    tick();
    chk("stop_k1_pwm", int'({PWM_L, PWM_R}), 0);
    chk("stop_k1_brake", int'(BRAKE), 1);
    chk("stop_k1_moving", int'(MOVING), 0);
    measure("stopped_a", 0, 0);
    measure("stopped_b", 0, 0);

    // Illegal code behaves as stop.
    DIR = 4'h0;
    wait_cnt(0);
    measure("restart5", 5, 5);
    measure("restart10", 10, 10);
    wait_cnt($urandom_range(1, 15));
    DIR = 4'h6;
    tick(); tick();
    chk("illegal_pwm", int'({PWM_L, PWM_R}), 0);
    chk("illegal_brake", int'(BRAKE), 1);
    measure("illegal_quiet", 0, 0);

    // One-cycle stop landing on a boundary: zero, not stepped.
    DIR = 4'h0;
    wait_cnt(0);
    measure("bstop_pre", 5, 5);
    wait_cnt(18);
    DIR = 4'hF;
    tick();
    DIR = 4'h0;
    tick();
    measure("bstop_zero", 0, 0);
    measure("bstop_restart", 5, 5);
    measure("bstop_ramp", 10, 10);

    // Asynchronous reset mid-ramp.
    wait_cnt(3);
    rst_n = 1'b0;
    #1 chk("async_rst_outs", int'({PWM_L, PWM_R, BRAKE, MOVING}), 4'b0010);
    tick();
    rst_n = 1'b1;
    wait_cnt(0);
    measure("post_rst", 5, 5);

    // Random codes, hold times and occasional resets against the model.
    repeat (60) begin
      DIR = ($urandom_range(0, 5) == 5) ? 4'($urandom) : codes[$urandom_range(0, 4)];
      repeat ($urandom_range(1, 40)) tick();
      if ($urandom_range(0, 14) == 0) begin
        rst_n = 1'b0;
        #1 chk("rand_rst_outs", int'({PWM_L, PWM_R, BRAKE, MOVING}), 4'b0010);
        tick();
        rst_n = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
